// File: rtl/riscv_wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// riscv_wb_stage_pkg
// Shared definitions for the RV32I write-back stage and its load aligner.
//   `XLEN          : datapath width macro (defaults to 32)
//   wb_src_e       : result source select carried with each retiring instruction
//   F3_*           : load funct3 encodings understood by the aligner
//   wb_state_e     : write-back FSM states
// No ports (package only).
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

package riscv_wb_stage_pkg;

  typedef enum logic [1:0] {
    WB_SRC_ALU  = 2'b00,
    WB_SRC_LOAD = 2'b01,
    WB_SRC_PC4  = 2'b10,
    WB_SRC_RSVD = 2'b11
  } wb_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/riscv_load_align.sv
// -----------------------------------------------------------------------------
// riscv_load_align
// Purely combinational load data aligner / extender.
// Ports:
//   i_raw    in  XLEN  raw aligned memory word
//   i_funct3 in  3     load type (LB/LH/LW/LBU/LHU)
//   i_lsb    in  2     byte address [1:0]
//   o_data   out XLEN  aligned, sign/zero-extended load data
//   o_err    out 1     illegal funct3 or misaligned access
// -----------------------------------------------------------------------------
module riscv_load_align
  import riscv_wb_stage_pkg::*;
#(
  parameter int XLEN = `XLEN
) (
  input  logic [XLEN-1:0] i_raw,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_lsb,
  output logic [XLEN-1:0] o_data,
  output logic            o_err
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    case (i_lsb)
      2'd0:    byte_w = i_raw[7:0];
      2'd1:    byte_w = i_raw[15:8];
      2'd2:    byte_w = i_raw[23:16];
      default: byte_w = i_raw[31:24];
    endcase
    half_w = i_lsb[1] ? i_raw[31:16] : i_raw[15:0];
  end

  always_comb begin
    o_data = '0;
    o_err  = 1'b0;
    case (i_funct3)
      F3_LB:  o_data = {{(XLEN-8){byte_w[7]}}, byte_w};
      F3_LBU: o_data = {{(XLEN-8){1'b0}}, byte_w};
      F3_LH: begin
        o_data = {{(XLEN-16){half_w[15]}}, half_w};
        o_err  = i_lsb[0];
      end
      F3_LHU: begin
        o_data = {{(XLEN-16){1'b0}}, half_w};
        o_err  = i_lsb[0];
      end
      F3_LW: begin
        o_data = i_raw;
        o_err  = (i_lsb != 2'b00);
      end
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_wb_stage.sv
// -----------------------------------------------------------------------------
// riscv_wb_stage
// RV32I write-back stage: accepts one retiring instruction per handshake,
// selects ALU / load / PC+4 result, waits for a late load response when
// needed, and issues a single registered write pulse to the register file.
// Ports:
//   i_clk, i_rstn                 clock, async active-low reset
//   i_wb_valid / o_wb_ready       handshake from memory stage
//   i_wb_rd_wen, i_wb_rd_addr     destination write enable / register
//   i_wb_src                      00 ALU, 01 LOAD, 10 PC+4, 11 reserved
//   i_wb_alu_result, i_wb_pc      result sources
//   i_wb_funct3, i_wb_addr_lsb    load type and byte offset
//   i_dmem_rsp_valid/_data        data-memory response
//   o_regfile_rd_wen/_addr/_data  register-file write port (registered)
//   o_wb_err                      one-cycle pulse on illegal source/load
//   o_instret                     64-bit retired instruction count
// -----------------------------------------------------------------------------
module riscv_wb_stage
  import riscv_wb_stage_pkg::*;
#(
  parameter int XLEN = `XLEN
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_wb_valid,
  output logic            o_wb_ready,
  input  logic            i_wb_rd_wen,
  input  logic [4:0]      i_wb_rd_addr,
  input  logic [1:0]      i_wb_src,
  input  logic [XLEN-1:0] i_wb_alu_result,
  input  logic [XLEN-1:0] i_wb_pc,
  input  logic [2:0]      i_wb_funct3,
  input  logic [1:0]      i_wb_addr_lsb,
  input  logic            i_dmem_rsp_valid,
  input  logic [XLEN-1:0] i_dmem_rsp_data,
  output logic            o_regfile_rd_wen,
  output logic [4:0]      o_regfile_rd_addr,
  output logic [XLEN-1:0] o_regfile_rd_data,
  output logic            o_wb_err,
  output logic [63:0]     o_instret
);

  wb_state_e state_q, state_d;

  // Fields captured when a load has to wait for its response
  logic       cap_wen_q,    cap_wen_d;
  logic [4:0] cap_rd_q,     cap_rd_d;
  logic [2:0] cap_funct3_q, cap_funct3_d;
  logic [1:0] cap_lsb_q,    cap_lsb_d;

  logic            rd_wen_q,  rd_wen_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            err_q,     err_d;
  logic [63:0]     instret_q, instret_d;

  logic            waiting;
  logic            complete;
  logic            sel_wen;
  logic [4:0]      sel_rd;
  logic [1:0]      sel_src;
  logic [2:0]      sel_funct3;
  logic [1:0]      sel_lsb;
  logic [XLEN-1:0] align_data;
  logic            align_err;
  logic [XLEN-1:0] result;
  logic            result_err;

  assign waiting    = (state_q == ST_WAIT_LOAD);
  assign o_wb_ready = (state_q == ST_IDLE);

  // One aligner serves both the same-cycle and the late response path
  assign sel_wen    = waiting ? cap_wen_q    : i_wb_rd_wen;
  assign sel_rd     = waiting ? cap_rd_q     : i_wb_rd_addr;
  assign sel_src    = waiting ? WB_SRC_LOAD  : i_wb_src;
  assign sel_funct3 = waiting ? cap_funct3_q : i_wb_funct3;
  assign sel_lsb    = waiting ? cap_lsb_q    : i_wb_addr_lsb;

  riscv_load_align #(.XLEN(XLEN)) u_load_align (
    .i_raw    (i_dmem_rsp_data),
    .i_funct3 (sel_funct3),
    .i_lsb    (sel_lsb),
    .o_data   (align_data),
    .o_err    (align_err)
  );

  always_comb begin
    result     = '0;
    result_err = 1'b0;
    case (sel_src)
      WB_SRC_ALU:  result = i_wb_alu_result;
      WB_SRC_LOAD: begin
        result     = align_data;
        result_err = align_err;
      end
      WB_SRC_PC4:  result = i_wb_pc + {{(XLEN-3){1'b0}}, 3'd4};
      default:     result_err = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= ST_IDLE;
      cap_wen_q    <= 1'b0;
      cap_rd_q     <= '0;
      cap_funct3_q <= '0;
      cap_lsb_q    <= '0;
      rd_wen_q     <= 1'b0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
      err_q        <= 1'b0;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      cap_wen_q    <= cap_wen_d;
      cap_rd_q     <= cap_rd_d;
      cap_funct3_q <= cap_funct3_d;
      cap_lsb_q    <= cap_lsb_d;
      rd_wen_q     <= rd_wen_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
      err_q        <= err_d;
      instret_q    <= instret_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    complete     = 1'b0;
    cap_wen_d    = cap_wen_q;
    cap_rd_d     = cap_rd_q;
    cap_funct3_d = cap_funct3_q;
    cap_lsb_d    = cap_lsb_q;

    case (state_q)
      ST_IDLE: begin
        if (i_wb_valid) begin
          if (i_wb_src == WB_SRC_LOAD && !i_dmem_rsp_valid) begin
            cap_wen_d    = i_wb_rd_wen;
            cap_rd_d     = i_wb_rd_addr;
            cap_funct3_d = i_wb_funct3;
            cap_lsb_d    = i_wb_addr_lsb;
            state_d      = ST_WAIT_LOAD;
          end else begin
            complete = 1'b1;
          end
        end
      end
      ST_WAIT_LOAD: begin
        if (i_dmem_rsp_valid) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Address/data follow every completion, even suppressed ones
    rd_wen_d  = complete && sel_wen && (sel_rd != 5'd0) && !result_err;
    err_d     = complete && result_err;
    rd_addr_d = complete ? sel_rd : rd_addr_q;
    rd_data_d = complete ? result : rd_data_q;
    instret_d = instret_q + {63'd0, complete};
  end

  assign o_regfile_rd_wen  = rd_wen_q;
  assign o_regfile_rd_addr = rd_addr_q;
  assign o_regfile_rd_data = rd_data_q;
  assign o_wb_err          = err_q;
  assign o_instret         = instret_q;

endmodule

// File: tb/tb_riscv_wb_stage.sv
module tb_riscv_wb_stage;

  logic        clk;
  logic        rstn;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_rd_wen;
  logic [4:0]  wb_rd_addr;
  logic [1:0]  wb_src;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_pc;
  logic [2:0]  wb_funct3;
  logic [1:0]  wb_addr_lsb;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rf_wen;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        wb_err;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_instret = 64'd0;

  riscv_wb_stage #(.XLEN(32)) dut (
    .i_clk             (clk),
    .i_rstn            (rstn),
    .i_wb_valid        (wb_valid),
    .o_wb_ready        (wb_ready),
    .i_wb_rd_wen       (wb_rd_wen),
    .i_wb_rd_addr      (wb_rd_addr),
    .i_wb_src          (wb_src),
    .i_wb_alu_result   (wb_alu_result),
    .i_wb_pc           (wb_pc),
    .i_wb_funct3       (wb_funct3),
    .i_wb_addr_lsb     (wb_addr_lsb),
    .i_dmem_rsp_valid  (rsp_valid),
    .i_dmem_rsp_data   (rsp_data),
    .o_regfile_rd_wen  (rf_wen),
    .o_regfile_rd_addr (rf_addr),
    .o_regfile_rd_data (rf_data),
    .o_wb_err          (wb_err),
    .o_instret         (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single cycle, then drop valid.
  task automatic issue(input logic [1:0] src, input logic wen, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] pc,
                       input logic [2:0] f3, input logic [1:0] lsb,
                       input logic rv, input logic [31:0] rd_word);
    wb_valid      = 1'b1;
    wb_src        = src;
    wb_rd_wen     = wen;
    wb_rd_addr    = rd;
    wb_alu_result = alu;
    wb_pc         = pc;
    wb_funct3     = f3;
    wb_addr_lsb   = lsb;
    rsp_valid     = rv;
    rsp_data      = rd_word;
    step();
    wb_valid  = 1'b0;
    rsp_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; wb_valid = 1'b0; wb_rd_wen = 1'b0; wb_rd_addr = '0; wb_src = '0;
    wb_alu_result = '0; wb_pc = '0; wb_funct3 = '0; wb_addr_lsb = '0;
    rsp_valid = 1'b0; rsp_data = '0;
    step(); step();

    // Reset state
    check("rst_wen",     {63'd0, rf_wen},   64'd0);
    check("rst_addr",    {59'd0, rf_addr},  64'd0);
    check("rst_data",    {32'd0, rf_data},  64'd0);
    check("rst_err",     {63'd0, wb_err},   64'd0);
    check("rst_instret", instret,           64'd0);
    check("rst_ready",   {63'd0, wb_ready}, 64'd1);
    rstn = 1'b1;
    step();

    // ALU result, rd=5
    issue(2'b00, 1'b1, 5'd5, 32'h1234_5678, 32'h0, 3'd0, 2'd0, 1'b0, 32'h0);
    exp_instret++;
    check("alu_wen",     {63'd0, rf_wen},  64'd1);
    check("alu_addr",    {59'd0, rf_addr}, 64'd5);
    check("alu_data",    {32'd0, rf_data}, 64'h1234_5678);
    check("alu_instret", instret,          exp_instret);
    step();
    check("alu_wen_drop", {63'd0, rf_wen},  64'd0);
    check("alu_data_hold", {32'd0, rf_data}, 64'h1234_5678);

    // LB / LBU at lsb=3 with same-cycle response
    issue(2'b01, 1'b1, 5'd3, 32'h0, 32'h0, 3'b000, 2'd3, 1'b1, 32'h80FF_FFFF);
    exp_instret++;
    check("lb_wen",  {63'd0, rf_wen},  64'd1);
    check("lb_data", {32'd0, rf_data}, 64'hFFFF_FF80);
    issue(2'b01, 1'b1, 5'd4, 32'h0, 32'h0, 3'b100, 2'd3, 1'b1, 32'h80FF_FFFF);
    exp_instret++;
    check("lbu_addr", {59'd0, rf_addr}, 64'd4);
    check("lbu_data", {32'd0, rf_data}, 64'h0000_0080);
    check("lbu_ready", {63'd0, wb_ready}, 64'd1);

    // LH rd=7 with delayed response; live funct3/lsb garbage while waiting
    issue(2'b01, 1'b1, 5'd7, 32'h0, 32'h0, 3'b001, 2'd2, 1'b0, 32'h0);
    wb_funct3 = 3'b010; wb_addr_lsb = 2'd1;
    check("lh_wait_ready1", {63'd0, wb_ready}, 64'd0);
    check("lh_wait_wen",    {63'd0, rf_wen},   64'd0);
    step();
    check("lh_wait_ready2", {63'd0, wb_ready}, 64'd0);
    step();
    check("lh_wait_ready3", {63'd0, wb_ready}, 64'd0);
    rsp_valid = 1'b1; rsp_data = 32'hBEEF_0000;
    step();
    rsp_valid = 1'b0;
    exp_instret++;
    check("lh_wen",     {63'd0, rf_wen},   64'd1);
    check("lh_addr",    {59'd0, rf_addr},  64'd7);
    check("lh_data",    {32'd0, rf_data},  64'hFFFF_BEEF);
    check("lh_ready",   {63'd0, wb_ready}, 64'd1);
    check("lh_instret", instret,           exp_instret);

    // Back-to-back ALU instructions
    wb_valid = 1'b1; wb_src = 2'b00; wb_rd_wen = 1'b1; wb_rd_addr = 5'd10;
    wb_alu_result = 32'hAAAA_0001;
    step();
    exp_instret++;
    check("b2b0_data", {32'd0, rf_data}, 64'hAAAA_0001);
    wb_rd_addr = 5'd11; wb_alu_result = 32'h5555_0002;
    step();
    wb_valid = 1'b0;
    exp_instret++;
    check("b2b1_wen",  {63'd0, rf_wen},  64'd1);
    check("b2b1_addr", {59'd0, rf_addr}, 64'd11);
    check("b2b1_data", {32'd0, rf_data}, 64'h5555_0002);

    // PC+4 wraps; rd=0 suppresses the strobe but still retires
    issue(2'b10, 1'b1, 5'd1, 32'h0, 32'hFFFF_FFFC, 3'd0, 2'd0, 1'b0, 32'h0);
    exp_instret++;
    check("pc4_wen",  {63'd0, rf_wen},  64'd1);
    check("pc4_data", {32'd0, rf_data}, 64'h0);
    issue(2'b10, 1'b1, 5'd0, 32'h0, 32'h0000_1000, 3'd0, 2'd0, 1'b0, 32'h0);
    exp_instret++;
    check("x0_wen",     {63'd0, rf_wen},  64'd0);
    check("x0_data",    {32'd0, rf_data}, 64'h0000_1004);
    check("x0_instret", instret,          exp_instret);

    // Error cases
    issue(2'b01, 1'b1, 5'd9, 32'h0, 32'h0, 3'b010, 2'd1, 1'b1, 32'h1111_2222);
    exp_instret++;
    check("lw_mis_err", {63'd0, wb_err}, 64'd1);
    check("lw_mis_wen", {63'd0, rf_wen}, 64'd0);
    step();
    check("err_drop", {63'd0, wb_err}, 64'd0);
    issue(2'b11, 1'b1, 5'd9, 32'h0, 32'h0, 3'd0, 2'd0, 1'b0, 32'h0);
    exp_instret++;
    check("src11_err", {63'd0, wb_err}, 64'd1);
    check("src11_wen", {63'd0, rf_wen}, 64'd0);
    issue(2'b01, 1'b1, 5'd9, 32'h0, 32'h0, 3'b101, 2'd1, 1'b1, 32'h1111_2222);
    exp_instret++;
    check("lhu_mis_err", {63'd0, wb_err}, 64'd1);
    issue(2'b01, 1'b1, 5'd9, 32'h0, 32'h0, 3'b011, 2'd0, 1'b1, 32'h1111_2222);
    exp_instret++;
    check("f3_011_err",     {63'd0, wb_err}, 64'd1);
    check("err_instret",    instret,         exp_instret);

    // Response in IDLE without a load accept is ignored
    rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
    step();
    rsp_valid = 1'b0;
    check("idle_rsp_wen",     {63'd0, rf_wen}, 64'd0);
    check("idle_rsp_instret", instret,         exp_instret);

    // Reset during WAIT_LOAD abandons the load
    issue(2'b01, 1'b1, 5'd12, 32'h0, 32'h0, 3'b010, 2'd0, 1'b0, 32'h0);
    check("wl_ready", {63'd0, wb_ready}, 64'd0);
    rstn = 1'b0;
    #1;
    check("wl_rst_ready",   {63'd0, wb_ready}, 64'd1);
    check("wl_rst_addr",    {59'd0, rf_addr},  64'd0);
    check("wl_rst_data",    {32'd0, rf_data},  64'd0);
    check("wl_rst_instret", instret,           64'd0);
    step();
    rstn = 1'b1;
    step();
    rsp_valid = 1'b1; rsp_data = 32'h7777_7777;
    step();
    rsp_valid = 1'b0;
    check("stale_wen",     {63'd0, rf_wen},  64'd0);
    check("stale_data",    {32'd0, rf_data}, 64'd0);
    check("stale_instret", instret,          64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_wb_stage.md
# riscv_wb_stage

Write-back stage of the RV32I core, and the writing client of `riscv_regfile`. It accepts one retiring instruction per handshake from the memory stage and selects the result source (ALU, load, link address). For loads it waits for the data-memory response when needed, then aligns and extends the data. It issues exactly one registered write pulse on the register-file write port, and also exposes that write for forwarding and retire counting.

## Interface
Parameters:
- `XLEN`, 32: datapath width; taken from `` `XLEN ``.

Ports:
- `i_clk`  in  1  core clock; all state updates on the rising edge.
- `i_rstn`  in  1  reset, asynchronous, active-low.
- `i_wb_valid`  in  1  memory stage presents an instruction.
- `o_wb_ready`  out  1  stage can accept an instruction.
- `i_wb_rd_wen`  in  1  instruction writes `rd`.
- `i_wb_rd_addr`  in  5  destination register.
- `i_wb_src`  in  2  result source: 00 ALU, 01 LOAD, 10 PC+4, 11 reserved.
- `i_wb_alu_result`  in  XLEN  ALU result.
- `i_wb_pc`  in  XLEN  instruction PC.
- `i_wb_funct3`  in  3  load type.
- `i_wb_addr_lsb`  in  2  load byte address [1:0].
- `i_dmem_rsp_valid`  in  1  load data valid this cycle.
- `i_dmem_rsp_data`  in  XLEN  raw aligned memory word.
- `o_regfile_rd_wen`  out  1  write strobe to the register file.
- `o_regfile_rd_addr`  out  5  write address.
- `o_regfile_rd_data`  out  XLEN  write data.
- `o_wb_err`  out  1  one-cycle pulse for an illegal source or load.
- `o_instret`  out  64  count of retired instructions.

## Operation
- State machine has two states, IDLE and WAIT_LOAD; the reset state is IDLE.
- `o_wb_ready` = (state == IDLE).
- Accept = `i_wb_valid` && `o_wb_ready`.
- IDLE, accept with src ALU or PC+4:
  - Register the result. ALU passes `i_wb_alu_result`; PC+4 is `i_wb_pc`+4, modulo 2^32.
  - Stay in IDLE.
- IDLE, accept with src LOAD:
  - If `i_dmem_rsp_valid` is high the same cycle, align the data and register it; stay in IDLE.
  - Otherwise capture rd, wen, funct3 and lsb, then go to WAIT_LOAD.
- WAIT_LOAD:
  - On `i_dmem_rsp_valid`, align the data with the captured fields, register the write, and go to IDLE.
  - Until then, hold with `o_wb_ready`=0.
- `i_dmem_rsp_valid` in IDLE without a LOAD accept is ignored.
- Load alignment:
  - LB (000) and LBU (100): select the byte at lsb.
  - LH (001) and LHU (101): select the halfword at lsb[1].
  - LW (010): pass the whole word.
  - LB and LH sign-extend; LBU and LHU zero-extend.
- Errors (no write, `o_wb_err` pulse, retire still counted):
  - funct3 011, 110 or 111;
  - LH or LHU with lsb[0]=1;
  - LW with lsb≠0;
  - src 11.
- `o_regfile_rd_wen` pulses for one cycle only when the instruction completes, wen=1, rd≠0, and there is no error. Writes to x0 are suppressed; the address and data are still updated.
- `o_instret` increments by 1 for every completed instruction, including suppressed and erroneous ones. It wraps from 2^64−1 to 0.

## Timing
- Reset values: `o_regfile_rd_wen`=0, `o_regfile_rd_addr`=0, `o_regfile_rd_data`=0, `o_wb_err`=0, `o_instret`=0, state IDLE, so `o_wb_ready`=1.
- Latency from accept (non-load, or load with a same-cycle response) to write strobe: 1 cycle.
- Latency from response in WAIT_LOAD to write strobe: 1 cycle. `o_wb_ready` returns to 1 in that same strobe cycle.
- Throughput is 1 instruction per cycle for back-to-back non-load instructions.
- Address and data hold their last value when the strobe is low.
- Reset asserted during WAIT_LOAD abandons the pending load. A later stale response is ignored.

## Structure
- Put the following in the shared `riscv_defines.vh`: `` `XLEN ``, the WB source encodings, and the load funct3 encodings.
- Sub-module `riscv_load_align` is purely combinational: inputs raw word, funct3 and lsb; outputs data and misalign/illegal. Instantiate it once, fed by a mux that picks live or captured fields.

## Test plan
- ALU src, rd=5, result 0x1234_5678 → next cycle strobe=1, addr=5, data=0x1234_5678; instret=1.
- LOAD LB with lsb=3, response word 0x80FF_FFFF on the same cycle → data=0xFFFF_FF80. Same case with LBU → data=0x0000_0080.
- LOAD LH rd=7 with no response for 3 cycles → ready=0 for 3 cycles. Response 0xBEEF_0000 with lsb=2 → strobe with data=0xFFFF_BEEF, and ready=1 in that cycle.
- PC+4 with pc=0xFFFF_FFFC, rd=1 → data=0x0000_0000. Same instruction with rd=0 → no strobe, instret still increments.
- LW with lsb=1, and separately src=11 → `o_wb_err` pulse, no strobe.
- Reset asserted in WAIT_LOAD → all outputs zero and ready=1. A response arriving afterwards produces no write.
